// File: rtl/arcade_input_mapper_if.sv
// Key-event and key-map write bus feeding the arcade input mapper.
interface arcade_input_mapper_if;
  logic [10:0] ps2_key;
  logic        map_wr;
  logic [4:0]  map_addr;
  logic [15:0] map_data;

  modport master (output ps2_key, map_wr, map_addr, map_data);
  modport slave  (input  ps2_key, map_wr, map_addr, map_data);
endinterface

// File: rtl/arcade_input_mapper.sv
// PS/2 key-map plus joystick merge into per-player arcade buttons,
// with autofire gating and stretched coin pulses.
module arcade_input_mapper #(
  parameter int          PLAYERS    = 2,
  parameter int          BTNS       = 8,
  parameter int          MAP_DEPTH  = 24,
  parameter int          COIN_IDX   = 7,
  parameter logic [15:0] COIN_LEN   = 16'd50000,
  parameter int          AF_IDX     = 4,
  parameter logic [15:0] AF_HALF    = 16'd20000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  arcade_input_mapper_if.slave    bus,
  input  logic [PLAYERS*16-1:0]   joy_in,
  input  logic                    joy_share,
  input  logic [PLAYERS-1:0]      af_en,
  output logic [PLAYERS*BTNS-1:0] btn,
  output logic [PLAYERS-1:0]      coin
);
  localparam int NB  = PLAYERS * BTNS;
  localparam int CW  = ($clog2(int'(COIN_LEN) + 1) < 1) ? 1 : $clog2(int'(COIN_LEN) + 1);
  localparam int AFW = ($clog2(int'(AF_HALF)) < 1) ? 1 : $clog2(int'(AF_HALF));

  logic [MAP_DEPTH-1:0] ent_valid;
  logic [MAP_DEPTH-1:0] ent_pressed;
  logic [8:0]           ent_code [MAP_DEPTH];
  logic [5:0]           ent_tgt  [MAP_DEPTH];
  logic                 tog_q;
  logic                 key_evt;

  logic [NB-1:0]        key_bit;
  logic [NB-1:0]        merged;
  logic [NB-1:0]        btn_nxt;

  logic [AFW-1:0]       af_cnt;
  logic                 phase;

  logic [PLAYERS-1:0]   coin_prev;
  logic [PLAYERS-1:0]   coin_lvl;
  logic [PLAYERS-1:0]   coin_nxt;
  logic [CW-1:0]        coin_cnt [PLAYERS];
  logic [CW-1:0]        cnt_nxt  [PLAYERS];

  logic                 unused_joy;
  assign unused_joy = ^joy_in;

  assign key_evt = bus.ps2_key[10] ^ tog_q;

  // Toggle register tracks ps2_key[10] even in reset so release never fakes an event.
  always_ff @(posedge clk_sys) begin
    tog_q <= bus.ps2_key[10];
    if (!reset_n) begin
      ent_valid   <= '0;
      ent_pressed <= '0;
    end else begin
      for (int i = 0; i < MAP_DEPTH; i++) begin
        if (bus.map_wr && int'(bus.map_addr) == i) begin
          ent_valid[i]   <= bus.map_data[15];
          ent_pressed[i] <= 1'b0;
        end else if (key_evt && ent_valid[i] && ent_code[i] == bus.ps2_key[8:0]) begin
          ent_pressed[i] <= bus.ps2_key[9];
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < MAP_DEPTH; i++) begin
      if (reset_n && bus.map_wr && int'(bus.map_addr) == i) begin
        ent_code[i] <= bus.map_data[14:6];
        ent_tgt[i]  <= bus.map_data[5:0];
      end
    end
  end

  always_comb begin
    key_bit = '0;
    for (int i = 0; i < MAP_DEPTH; i++) begin
      for (int t = 0; t < NB; t++) begin
        if (ent_valid[i] && ent_pressed[i] && int'(ent_tgt[i]) == t) key_bit[t] = 1'b1;
      end
    end
  end

  always_comb begin
    merged  = '0;
    btn_nxt = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      for (int j = 0; j < BTNS; j++) begin
        merged[p*BTNS+j]  = key_bit[p*BTNS+j] | joy_in[p*16+j] | (joy_share & joy_in[j]);
        btn_nxt[p*BTNS+j] = (j == AF_IDX && af_en[p]) ? (merged[p*BTNS+j] & phase)
                                                       : merged[p*BTNS+j];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      af_cnt <= '0;
      phase  <= 1'b0;
    end else if (af_cnt == '0) begin
      af_cnt <= AFW'(AF_HALF - 16'd1);
      phase  <= ~phase;
    end else begin
      af_cnt <= af_cnt - AFW'(1);
    end
  end

  // A coin edge only loads an idle counter; edges inside a running pulse are dropped.
  always_comb begin
    coin_lvl = '0;
    coin_nxt = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      coin_lvl[p] = merged[p*BTNS+COIN_IDX];
      cnt_nxt[p]  = coin_cnt[p];
      if (coin_cnt[p] != '0)
        cnt_nxt[p] = coin_cnt[p] - CW'(1);
      else if (coin_lvl[p] && !coin_prev[p])
        cnt_nxt[p] = CW'(COIN_LEN);
      coin_nxt[p] = (cnt_nxt[p] != '0);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      btn       <= {NB{ACTIVE_LOW}};
      coin      <= {PLAYERS{ACTIVE_LOW}};
      coin_prev <= '0;
      for (int p = 0; p < PLAYERS; p++) coin_cnt[p] <= '0;
    end else begin
      btn       <= btn_nxt ^ {NB{ACTIVE_LOW}};
      coin      <= coin_nxt ^ {PLAYERS{ACTIVE_LOW}};
      coin_prev <= coin_lvl;
      for (int p = 0; p < PLAYERS; p++) coin_cnt[p] <= cnt_nxt[p];
    end
  end
endmodule
